// File: rtl/regfile_reader.sv
// Burst read-out engine for the regfile: issues addresses, absorbs the one-cycle read latency
// and streams words on a valid/ready port. Define REGFILE_READER_PARITY_EN to add out_parity.
module regfile_reader #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned ADDRESSWIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] start_addr,
    input  logic [ADDRESSWIDTH:0]   count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESSWIDTH-1:0] rf_source,
    input  logic [WIDTH-1:0]        rf_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [ADDRESSWIDTH-1:0] out_addr,
    output logic                    out_last
`ifdef REGFILE_READER_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    localparam logic [ADDRESSWIDTH-1:0] LastAddr = ADDRESSWIDTH'(DEPTH - 1);
    localparam logic [ADDRESSWIDTH:0]   OneLeft  = (ADDRESSWIDTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StSend} state_e;

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [ADDRESSWIDTH:0]   remaining_q, remaining_d;
    logic                    done_d;
    logic                    capture;

    logic                    busy_q, done_q, out_valid_q, out_last_q;
    logic [ADDRESSWIDTH-1:0] rf_source_q, out_addr_q;
    logic [WIDTH-1:0]        out_data_q;
`ifdef REGFILE_READER_PARITY_EN
    logic                    out_parity_q;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d      = start_addr;
                        remaining_d = count;
                        state_d     = StIssue;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                capture = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        addr_d      = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            rf_source_q  <= '0;
`ifdef REGFILE_READER_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= done_d;
            out_valid_q <= (state_d == StSend);
            if (state_d == StIssue) begin
                rf_source_q <= addr_d;
            end
            if (capture) begin
                out_data_q   <= rf_data;
                out_addr_q   <= addr_q;
                out_last_q   <= (remaining_q == OneLeft);
`ifdef REGFILE_READER_PARITY_EN
                out_parity_q <= ^rf_data;
`endif
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign rf_source  = rf_source_q;
`ifdef REGFILE_READER_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: table-driven bursts, hand-written corner sequences and
// randomized bursts checked against a queue-based model of the expected word stream.
module tb_regfile_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [4:0]  rf_source;
    logic [15:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
`ifdef REGFILE_READER_PARITY_EN
    logic        out_parity;
`endif

    regfile_reader #(
        .WIDTH       (16),
        .DEPTH       (3),
        .ADDRESSWIDTH(5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rf_source (rf_source),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
`ifdef REGFILE_READER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile model: registered read of the pre-write contents, one write port.
    logic [15:0] rf_mem [3];
    logic        we;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    always @(posedge clock) begin
        rf_data <= (rf_source < 5'd3) ? rf_mem[rf_source[1:0]] : 16'h0;
        if (we) rf_mem[waddr] <= wdata;
    end

    int nerr = 0;
    int nchecks = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic [4:0]  sa;
        logic [5:0]  cnt;
        int          stall;
        bit          inject;
        bit          hazard;
        logic [15:0] exp_first_data;
        logic [4:0]  exp_last_addr;
    } vec_t;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 0);
        chk({tag, "_out_data"}, {16'd0, out_data}, 0);
        chk({tag, "_out_addr"}, {27'd0, out_addr}, 0);
        chk({tag, "_rf_source"}, {27'd0, rf_source}, 0);
`ifdef REGFILE_READER_PARITY_EN
        chk({tag, "_out_parity"}, {31'd0, out_parity}, 0);
`endif
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic run_burst(input logic [4:0] sa, input logic [5:0] cnt, input int stall,
                             input bit inject, input bit hazard, input bit rnd_ready,
                             output logic [15:0] first_data, output logic [4:0] last_addr);
        word_t exp_q[$];
        word_t e;
        int    words = 0;
        int    wait_cnt = 1;
        int    stall_cnt = 0;
        int    guard = 0;
        bit    seen = 0;
        bit    hs;
        first_data = 'x;
        last_addr = 'x;
        for (int i = 0; i < int'(cnt); i++) begin
            e.addr = 5'((int'(sa) + i) % 3);
            e.data = rf_mem[e.addr[1:0]];
            e.last = (i == int'(cnt) - 1);
            exp_q.push_back(e);
        end
        start = 1'b1;
        start_addr = sa;
        count = cnt;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        if (hazard) begin
            we = 1'b1;
            waddr = sa[1:0];
            wdata = 16'hABCD;
        end
        while (words < int'(cnt) && guard < 400) begin
            hs = 1'b0;
            e = exp_q[words];
            if (wait_cnt == 1) chk("rf_source_issue", {27'd0, rf_source}, {27'd0, e.addr});
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("valid_latency", wait_cnt, 3);
                    if (words == 0) first_data = out_data;
                    last_addr = out_addr;
                end
                chk("out_data", {16'd0, out_data}, {16'd0, e.data});
                chk("out_addr", {27'd0, out_addr}, {27'd0, e.addr});
                chk("out_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef REGFILE_READER_PARITY_EN
                chk("out_parity", {31'd0, out_parity}, {31'd0, ^e.data});
`endif
                if (words == 0 && stall_cnt < stall) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                hs = out_ready;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (inject && words == 0 && wait_cnt == 2) begin
                start = 1'b1;
                start_addr = 5'd0;
                count = 6'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            we = 1'b0;
            guard++;
            if (hs) begin
                if (e.last) begin
                    chk("done_after_last", {31'd0, done}, 1);
                    chk("busy_after_last", {31'd0, busy}, 0);
                    chk("valid_after_last", {31'd0, out_valid}, 0);
                end
                words++;
                wait_cnt = 1;
                seen = 1'b0;
            end else begin
                wait_cnt++;
            end
        end
        start = 1'b0;
        chk("burst_complete", words, int'(cnt));
        out_ready = 1'b0;
        tick();
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
    endtask

    vec_t        vecs [6];
    logic [15:0] fd;
    logic [4:0]  la;
    int          nvalid;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        start_addr = '0;
        count = '0;
        out_ready = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        wr(2'd0, 16'h1111);
        wr(2'd1, 16'h2222);
        wr(2'd2, 16'h3333);

        vecs[0] = '{5'd0, 6'd3, 0, 1'b0, 1'b0, 16'h1111, 5'd2};
        vecs[1] = '{5'd2, 6'd4, 0, 1'b0, 1'b0, 16'h3333, 5'd2};
        vecs[2] = '{5'd0, 6'd2, 5, 1'b0, 1'b0, 16'h1111, 5'd1};
        vecs[3] = '{5'd1, 6'd3, 0, 1'b1, 1'b0, 16'h2222, 5'd0};
        vecs[4] = '{5'd1, 6'd1, 0, 1'b0, 1'b1, 16'h2222, 5'd1};
        vecs[5] = '{5'd1, 6'd2, 0, 1'b0, 1'b0, 16'hABCD, 5'd2};
        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].sa, vecs[v].cnt, vecs[v].stall, vecs[v].inject, vecs[v].hazard,
                      1'b0, fd, la);
            chk($sformatf("vec%0d_first_data", v), {16'd0, fd}, {16'd0, vecs[v].exp_first_data});
            chk($sformatf("vec%0d_last_addr", v), {27'd0, la}, {27'd0, vecs[v].exp_last_addr});
        end

        // Zero-length burst.
        start = 1'b1;
        start_addr = 5'd1;
        count = 6'd0;
        tick();
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_busy", {31'd0, busy}, 0);
        chk("zero_valid", {31'd0, out_valid}, 0);
        tick();
        chk("zero_done_once", {31'd0, done}, 0);
        chk("zero_valid_later", {31'd0, out_valid}, 0);

        // Reset during the second SEND.
        out_ready = 1'b1;
        start = 1'b1;
        start_addr = 5'd0;
        count = 6'd3;
        tick();
        start = 1'b0;
        nvalid = 0;
        for (int g = 0; g < 40 && nvalid < 2; g++) begin
            if (out_valid) nvalid++;
            if (nvalid < 2) tick();
        end
        chk("reset_reached_second_send", nvalid, 2);
        reset = 1'b0;
        tick();
        chk_all_zero("midreset");
        reset = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_reset_no_done", {31'd0, done}, 0);
            chk("post_reset_no_valid", {31'd0, out_valid}, 0);
        end
        run_burst(5'd2, 6'd2, 0, 1'b0, 1'b0, 1'b0, fd, la);
        chk("post_reset_first_data", {16'd0, fd}, {16'd0, rf_mem[2]});

`ifdef REGFILE_READER_PARITY_EN
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0003);
        run_burst(5'd0, 6'd2, 0, 1'b0, 1'b0, 1'b0, fd, la);
`endif

        // Randomized bursts with random backpressure.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 3; a++) wr(2'(a), 16'($urandom));
            run_burst(5'($urandom_range(0, 2)), 6'($urandom_range(1, 7)), 0, 1'b0, 1'b0, 1'b1,
                      fd, la);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential read-out engine for the `regfile` block. It drives the register file's `source` address, absorbs the one-cycle registered read latency, and presents each word on a valid/ready output stream with backpressure. A `start` pulse triggers a burst of `count` consecutive entries beginning at `start_addr`, wrapping at `DEPTH`. It sits between `regfile` and any consumer that drains register contents, such as a debug dump, context save or scan-out.

## Interface
- `WIDTH`, 16, data word width; must match the regfile.
- `DEPTH`, 3, number of regfile entries; address wrap point.
- `ADDRESSWIDTH`, 5, address width; must match the regfile.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: begin a burst; sampled only in IDLE.
- `start_addr` input ADDRESSWIDTH: first entry; must be < DEPTH.
- `count` input ADDRESSWIDTH+1: number of words in the burst; 0 is legal.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a burst completes.
- `rf_source` output ADDRESSWIDTH: connects to regfile `source`.
- `rf_data` input WIDTH: connects to regfile `data_out`.
- `out_valid` output 1: `out_data`, `out_addr` and `out_last` are valid.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output WIDTH: word read.
- `out_addr` output ADDRESSWIDTH: entry the word came from.
- `out_last` output 1: final word of the burst.

## Operation
- FSM states: IDLE, ISSUE, WAIT, SEND.
- IDLE:
  - `start`=1 and `count`≠0: latch `addr`=`start_addr` and `remaining`=`count`; go to ISSUE.
  - `start`=1 and `count`=0: pulse `done` next cycle; stay in IDLE.
- ISSUE: `rf_source`=`addr`. The regfile samples the address at the end of this cycle. Next state is WAIT.
- WAIT: `rf_data` holds `rf[addr]`. At the end of the cycle, capture `rf_data` into `out_data`, capture `addr` into `out_addr`, and set `out_last` = (`remaining`==1). Go to SEND.
- SEND: `out_valid`=1. `out_data`, `out_addr` and `out_last` stay stable until `out_valid && out_ready`.
  - Handshake with `out_last`=1: go to IDLE and pulse `done` the same cycle IDLE is entered.
  - Handshake otherwise: `addr` = (`addr`==DEPTH-1) ? 0 : `addr`+1; `remaining` -= 1; go to ISSUE.
- `rf_source` holds the last issued address outside ISSUE. It is 0 after reset.
- `start` outside IDLE is ignored; no queuing.
- Write hazard: the word returned is the regfile content before any write landing on the ISSUE clock edge. A write to `addr` during WAIT or SEND is not reflected.
- `count` > DEPTH is legal: addresses wrap and entries are read again in order.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE. All outputs are 0: `busy`, `done`, `out_valid`, `out_last`, `out_data`, `out_addr`, `rf_source`.
- Reset mid-burst aborts immediately. No `done` is issued and no partial word is presented.
- `start` sampled at edge E: ISSUE in the cycle after E, WAIT one cycle later, `out_valid` high 3 cycles after E.
- Each word takes 3 cycles if `out_ready` is held high. Throughput is 1 word per 3 cycles.
- `done` rises the cycle after the final handshake and lasts exactly 1 cycle. `busy` is 0 in that same cycle.
- A new `start` is accepted in the same cycle `done` is high.
- All outputs are registered. There is no combinational path from `out_ready` to any output.

## Configuration
- `REGFILE_READER_PARITY_EN`
  - Defined: adds output `out_parity` (1 bit) = XOR-reduction of `out_data`. It is registered alongside `out_data`, stable while `out_valid`, and 0 at reset.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic burst: regfile preloaded with rf[0..2] = 16'h1111, 2222, 3333; `start_addr`=0, `count`=3, `out_ready`=1. Required: words 1111/2222/3333 with `out_addr` 0/1/2, `out_last` only on 3333, first `out_valid` 3 cycles after `start`, `done` 1 cycle after the last handshake.
- Wrap: `start_addr`=2, `count`=4. Required: `out_addr` sequence 2, 0, 1, 2 with matching data.
- Backpressure: `out_ready`=0 for 5 cycles in the first SEND. Required: `out_valid` held high with stable data/addr; the next ISSUE only follows the handshake.
- Corner cases:
  - `count`=0: `done` pulse the next cycle, `out_valid` never asserted.
  - `start` asserted while `busy`: ignored, burst unaffected.
- Reset mid-burst: assert `reset`=0 during the second SEND. Required: all outputs 0 the next cycle, no `done`. A subsequent burst runs correctly.
- Write hazard and parity:
  - Write 16'hABCD to entry 1 on the ISSUE edge for address 1: word returns the old value.
  - With `REGFILE_READER_PARITY_EN`: `out_parity`=1 for 16'h0001 and 0 for 16'h0003.
